// File: rtl/display_scroll_ctrl_pkg.sv
// Shared display definitions: controller states, field widths and the
// disp_word layout consumed by the 4-digit seven-segment driver.
package display_scroll_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int POS_W    = 3;
  localparam int DIGITS_W = 16;
  localparam int DISP_W   = 20;

  // disp_word layout: {pad, pos, digits}
  localparam int DISP_DIG_LSB = 0;
  localparam int DISP_POS_LSB = 16;
  localparam int DISP_PAD_BIT = 19;

  // Assemble the driver word; the pad bit is always zero.
  function automatic logic [DISP_W-1:0] pack_disp(input logic [POS_W-1:0]    pos,
                                                  input logic [DIGITS_W-1:0] digits);
    logic [DISP_W-1:0] w;
    w = '0;
    w[DISP_POS_LSB +: POS_W]    = pos;
    w[DISP_DIG_LSB +: DIGITS_W] = digits;
    w[DISP_PAD_BIT]             = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/display_scroll_ctrl_tick.sv
// Scroll prescaler: free-running counter that advances only while enabled
// and flags a tick whenever its low BASE_W+speed_sel bits are all ones.
module scroll_tick_gen #(
  parameter int BASE_W = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [1:0] speed_sel,
  output logic       tick
);

  localparam int CNT_W = BASE_W + 3;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] mask;

  // Mask of the bits that must be all ones for a tick; speed_sel=3 covers
  // the whole counter because the shift then pushes every one out.
  always_comb begin
    mask = ~({CNT_W{1'b1}} << (BASE_W + int'(speed_sel)));
  end

  // Counter holds when disabled and wraps naturally when enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Tick is only meaningful while counting.
  always_comb begin
    tick = en & (&(cnt | ~mask));
  end

endmodule

// File: rtl/display_scroll_ctrl.sv
// Scroll controller for a 4-digit hex display: IDLE/RUN/PAUSE control,
// value loading, position stepping on prescaler ticks and a registered
// driver word with a wrap indication aligned to it.
module display_scroll_ctrl
  import display_scroll_ctrl_pkg::*;
#(
  parameter int BASE_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [15:0]       data_in,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  input  logic [1:0]        speed_sel,
  output logic [DISP_W-1:0] disp_word,
  output logic              busy,
  output logic              wrap_pulse
);

  state_t              state;
  state_t              state_nxt;
  logic [POS_W-1:0]    pos;
  logic [DIGITS_W-1:0] digits;
  logic                wrap_p0;
  logic                tick;
  logic                load_acc;
  logic                idle_entry;

  // Status outputs and handshake decoded straight from the state.
  always_comb begin
    busy       = (state == ST_RUN);
    load_ready = (state != ST_RUN);
    load_acc   = load_valid & load_ready;
    idle_entry = (state == ST_PAUSE) & stop;
  end

  // Next-state logic; stop always wins over start.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (!stop && start) state_nxt = ST_RUN;
      ST_RUN:   if (stop)           state_nxt = ST_PAUSE;
      ST_PAUSE: if (stop)           state_nxt = ST_IDLE;
                else if (start)     state_nxt = ST_RUN;
      default:                      state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  scroll_tick_gen #(
    .BASE_W(BASE_W)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (load_acc | idle_entry),
    .en       (busy),
    .speed_sel(speed_sel),
    .tick     (tick)
  );

  // Position and digit registers; ticks only occur in RUN and loads only
  // outside RUN, so the two never compete on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos     <= '0;
      digits  <= '0;
      wrap_p0 <= 1'b0;
    end else begin
      wrap_p0 <= 1'b0;
      if (tick) begin
        if (dir) begin
          pos     <= pos - POS_W'(1);
          wrap_p0 <= (pos == '0);
        end else begin
          pos     <= pos + POS_W'(1);
          wrap_p0 <= (pos == '1);
        end
      end
      if (load_acc) begin
        digits <= data_in;
        pos    <= '0;
      end
      if (idle_entry) begin
        pos <= '0;
      end
    end
  end

  // ---- output stage: driver word and wrap pulse share one cycle of delay
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_word  <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      disp_word  <= pack_disp(pos, digits);
      wrap_pulse <= wrap_p0;
    end
  end

endmodule

// File: doc/display_scroll_ctrl.md
DISPLAY_SCROLL_CTRL -- requirements
Module: display_scroll_ctrl

Interface
REQ-001 Parameter BASE_W, default 21: log2 of the fastest scroll-tick period in clk cycles.
REQ-002 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-high.
REQ-004 Port load_valid, input, 1: a new 4-digit hex value is offered on data_in.
REQ-005 Port load_ready, output, 1: the block accepts a load this cycle.
REQ-006 Port data_in, input, 16: four hex digits; [3:0] is digit 0 and [15:12] is digit 3.
REQ-007 Port start, input, 1: level; requests scrolling.
REQ-008 Port stop, input, 1: level; requests pause, or idle when already paused.
REQ-009 Port dir, input, 1: 0 selects position increment, 1 selects decrement.
REQ-010 Port speed_sel, input, 2: tick period is 2^(BASE_W+speed_sel) clk cycles.
REQ-011 Port disp_word, output, 20: registered word for the 4-digit seven-segment driver, {1'b0, pos[2:0], digits[15:0]}.
REQ-012 Port busy, output, 1: high while in RUN.
REQ-013 Port wrap_pulse, output, 1: one-cycle pulse when pos wraps.

Function
REQ-014 States are IDLE, RUN and PAUSE.
REQ-015 IDLE goes to RUN on start=1 and stop=0.
REQ-016 RUN goes to PAUSE on stop=1.
REQ-017 PAUSE goes to RUN on start=1 and stop=0.
REQ-018 PAUSE goes to IDLE on stop=1.
REQ-019 Priority: stop=1 wins over start=1 in the same cycle.
REQ-020 Entering IDLE forces pos to 0 and the prescaler to 0 on the same edge.
REQ-021 load_ready is 1 in IDLE and PAUSE and 0 in RUN; it is decoded combinationally from state.
REQ-022 On load_valid & load_ready, the block captures data_in into the digit register, clears pos to 0 and clears the prescaler; the state is unchanged.
REQ-023 load_valid while load_ready=0 is ignored; the source must hold it until accepted.
REQ-024 Prescaler behaviour:
  - width BASE_W+3 bits;
  - counts only in RUN and holds its value in PAUSE;
  - the tick is 1 when the low BASE_W+speed_sel bits are all ones;
  - the prescaler wraps naturally.
REQ-025 A change of speed_sel takes effect immediately; no prescaler reset is applied.
REQ-026 On a tick in RUN, pos becomes pos+1 mod 8 when dir=0, or pos-1 mod 8 when dir=1.
REQ-027 wrap_pulse is 1 in the cycle after a 7->0 increment or a 0->7 decrement; otherwise it is 0.
REQ-028 A tick and a stop in the same cycle: the pos update still occurs and the state moves to PAUSE.
REQ-029 disp_word is updated one cycle after any change of pos or digits; there are no other sources of latency.
REQ-030 disp_word[19] is always 0.
REQ-031 busy equals (state==RUN), decoded combinationally.

Reset
REQ-032 On rst=1 at a clock edge:
  - state=IDLE;
  - digits=0, pos=0, prescaler=0;
  - disp_word=20'h00000, wrap_pulse=0;
  - hence busy=0 and load_ready=1.
REQ-033 rst has priority over every other input, including mid-RUN and simultaneous load.

Structure
REQ-034 The shared display package holds:
  - the state enum;
  - POS_W=3, DIGITS_W=16 and DISP_W=20;
  - the disp_word field offsets, shared with the 4-digit driver.
REQ-035 The prescaler and tick decode are one sub-module, scroll_tick_gen (parameter BASE_W; inputs clk, rst, clr, en, speed_sel; output tick).
REQ-036 All other logic is flat in display_scroll_ctrl.

Verification (BASE_W=2)
REQ-037 Reset then load data_in=16'hABCD -> disp_word=20'h0ABCD the next cycle; busy=0; load_ready=1.
REQ-038 Load 16'h1234, start, speed_sel=0, dir=0 -> pos increments every 4 cycles: 20'h11234, 20'h21234, ..., 20'h71234, then 20'h01234 with wrap_pulse high for exactly one cycle.
REQ-039 In RUN, dir=1 from pos=0 -> the next tick gives pos=7 (disp_word=20'h7xxxx) and wrap_pulse=1.
REQ-040 stop in RUN at pos=3 -> PAUSE; pos holds for more than 64 cycles; load 16'h5555 is accepted and gives disp_word=20'h05555; start resumes with the first tick 4 cycles later.
REQ-041 start and stop both high in IDLE -> stays IDLE; both high in PAUSE -> IDLE with pos=0.
REQ-042 rst asserted mid-RUN at pos=5 with load_valid=1 -> next cycle disp_word=0, busy=0, load_ready=1, wrap_pulse=0.
